ddr3_core_arb: RTL and testbench

//  Two-port round-robin arbiter sharing the single native request port of ddr3_core between requesters.
//  The arbiter sits between two ddr3_axi_pmem-style masters and ddr3_core.
//  It tags each request with its source in req_id[15] and routes acks/read data back by that tag.
//  It also caps in-flight requests per port.

---
 rtl/ddr3_core_arb_pkg.sv | 27 ++
 rtl/ddr3_core_arb_if.sv | 39 +++
 rtl/ddr3_arb_outstanding.sv | 50 +++++
 rtl/ddr3_core_arb.sv | 152 +++++++++++++++
 tb/tb_ddr3_core_arb.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr3_core_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_core_arb_pkg
//   Shared definitions for the two-port ddr3_core request arbiter.
//   - DDR3_ARB_PORT_BIT : bit of the 16-bit core request/response id that
//                         carries the source/destination port number.
//   - DDR3_ARB_PORTS    : number of requester ports.
//   - DDR3_ARB_TAG_W    : width of the requester-side tag.
//   - lock_state_t      : whether the grant is pinned to one port.
//   - req_valid()       : a request is present when any write enable or the
//                         read strobe is set.
// ----------------------------------------------------------------------------
package ddr3_core_arb_pkg;

  localparam int DDR3_ARB_PORT_BIT = 15;
  localparam int DDR3_ARB_PORTS    = 2;
  localparam int DDR3_ARB_TAG_W    = 15;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  function automatic logic req_valid(input logic [15:0] wr, input logic rd);
    return (|wr) | rd;
  endfunction

endpackage

// File: rtl/ddr3_core_arb_if.sv
// ----------------------------------------------------------------------------
// ddr3_core_arb_if
//   Native ddr3_core style request/response bus.
//   Requester side uses ID_W = 15, the core side uses ID_W = 16 (port tag on
//   top).
//   Request  (master -> slave): wr[15:0], rd, addr[31:0], write_data[127:0],
//                               req_id[ID_W-1:0]
//   Response (slave -> master): accept, ack, error, read_data[127:0],
//                               resp_id[ID_W-1:0]
// ----------------------------------------------------------------------------
interface ddr3_core_arb_if
  import ddr3_core_arb_pkg::*;
#(
  parameter int ID_W = DDR3_ARB_TAG_W
);

  logic [15:0]     wr;
  logic            rd;
  logic [31:0]     addr;
  logic [127:0]    write_data;
  logic [ID_W-1:0] req_id;

  logic            accept;
  logic            ack;
  logic            error;
  logic [127:0]    read_data;
  logic [ID_W-1:0] resp_id;

  modport master (
    output wr, rd, addr, write_data, req_id,
    input  accept, ack, error, read_data, resp_id
  );

  modport slave (
    input  wr, rd, addr, write_data, req_id,
    output accept, ack, error, read_data, resp_id
  );

endinterface

// File: rtl/ddr3_arb_outstanding.sv
// ----------------------------------------------------------------------------
// ddr3_arb_outstanding
//   Per-port count of accepted-but-unacknowledged requests.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     inc      : a request from this port was accepted this cycle
//     dec      : a response for this port was returned this cycle
//     full     : count has reached OUTSTANDING_MAX
// ----------------------------------------------------------------------------
module ddr3_arb_outstanding #(
  parameter int OUTSTANDING_MAX = 8,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept and ack in the same cycle cancel out. A response arriving with the
  // count already at zero (stray, e.g. issued before a reset) is ignored
  // rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full = (cnt_q == CNT_W'(OUTSTANDING_MAX));

endmodule

// File: rtl/ddr3_core_arb.sv
// ----------------------------------------------------------------------------
// ddr3_core_arb
//   Round-robin arbiter sharing the native request port of ddr3_core between
//   two requesters. Requests are tagged with their source port in req_id[15];
//   responses are steered back by resp_id[15]. Each port is limited to
//   OUTSTANDING_MAX accepted-but-unacked requests.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     p0, p1   : requester buses (slave side, 15-bit tags)
//     outport  : bus towards ddr3_core (master side, 16-bit ids)
// ----------------------------------------------------------------------------
module ddr3_core_arb
  import ddr3_core_arb_pkg::*;
#(
  parameter int OUTSTANDING_MAX = 8,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  ddr3_core_arb_if.slave   p0,
  ddr3_core_arb_if.slave   p1,
  ddr3_core_arb_if.master  outport
);

  lock_state_t lock_q;
  lock_state_t lock_d;
  logic        lock_port_q;
  logic        lock_port_d;
  logic        rr_last_q;
  logic        rr_last_d;

  logic [DDR3_ARB_PORTS-1:0] valid;
  logic [DDR3_ARB_PORTS-1:0] full;
  logic [DDR3_ARB_PORTS-1:0] elig;
  logic [DDR3_ARB_PORTS-1:0] accept_vec;
  logic [DDR3_ARB_PORTS-1:0] ack_vec;

  logic grant_valid;
  logic grant;

  assign valid[0] = req_valid(p0.wr, p0.rd);
  assign valid[1] = req_valid(p1.wr, p1.rd);
  assign elig     = valid & ~full;

  // Grant selection. Once a request has been shown to the core without being
  // accepted the grant stays on that port, so the core never sees the request
  // change under it. Reset forces no grant so the outport goes quiet at once.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (rst) begin
      grant_valid = 1'b0;
    end else if (lock_q == LOCK_HELD) begin
      grant_valid = 1'b1;
      grant       = lock_port_q;
    end else if (elig[0] && elig[1]) begin
      grant_valid = 1'b1;
      grant       = ~rr_last_q;
    end else if (elig[0]) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (elig[1]) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  // Request mux towards the core; only the strobes are gated by the grant.
  always_comb begin
    outport.wr         = '0;
    outport.rd         = 1'b0;
    if (grant_valid) begin
      outport.wr = grant ? p1.wr : p0.wr;
      outport.rd = grant ? p1.rd : p0.rd;
    end
    outport.addr       = grant ? p1.addr       : p0.addr;
    outport.write_data = grant ? p1.write_data : p0.write_data;
    outport.req_id     = {grant, (grant ? p1.req_id : p0.req_id)};
  end

  assign accept_vec[0] = grant_valid & ~grant & outport.accept;
  assign accept_vec[1] = grant_valid &  grant & outport.accept;

  assign p0.accept = accept_vec[0];
  assign p1.accept = accept_vec[1];

  // Responses: ack is steered by the port tag, everything else is broadcast.
  assign ack_vec[0] = ~rst & outport.ack & ~outport.resp_id[DDR3_ARB_PORT_BIT];
  assign ack_vec[1] = ~rst & outport.ack &  outport.resp_id[DDR3_ARB_PORT_BIT];

  assign p0.ack       = ack_vec[0];
  assign p1.ack       = ack_vec[1];
  assign p0.error     = outport.error;
  assign p1.error     = outport.error;
  assign p0.read_data = outport.read_data;
  assign p1.read_data = outport.read_data;
  assign p0.resp_id   = outport.resp_id[DDR3_ARB_PORT_BIT-1:0];
  assign p1.resp_id   = outport.resp_id[DDR3_ARB_PORT_BIT-1:0];

  // Lock and round-robin next state. A stalled grant pins the port; the
  // accept releases the lock and records the winner for the next tie.
  always_comb begin
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    rr_last_d   = rr_last_q;
    if (grant_valid) begin
      if (outport.accept) begin
        lock_d    = LOCK_OPEN;
        rr_last_d = grant;
      end else begin
        lock_d      = LOCK_HELD;
        lock_port_d = grant;
      end
    end
  end

  // rr_last resets to port 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q      <= LOCK_OPEN;
      lock_port_q <= 1'b0;
      rr_last_q   <= 1'b1;
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
      rr_last_q   <= rr_last_d;
    end
  end

  ddr3_arb_outstanding #(
    .OUTSTANDING_MAX (OUTSTANDING_MAX),
    .CNT_W           (CNT_W)
  ) u_cnt0 (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept_vec[0]),
    .dec  (ack_vec[0]),
    .full (full[0])
  );

  ddr3_arb_outstanding #(
    .OUTSTANDING_MAX (OUTSTANDING_MAX),
    .CNT_W           (CNT_W)
  ) u_cnt1 (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept_vec[1]),
    .dec  (ack_vec[1]),
    .full (full[1])
  );

endmodule

// File: tb/tb_ddr3_core_arb.sv
// ----------------------------------------------------------------------------
// tb_ddr3_core_arb
//   Directed scenarios followed by randomized traffic for ddr3_core_arb.
//   A behavioural model (per-port outstanding counts, pinned port, last
//   winner) predicts the outport request and per-port accept/ack every cycle.
// ----------------------------------------------------------------------------
module tb_ddr3_core_arb;

  localparam int OMAX = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ddr3_core_arb_if #(.ID_W(15)) p0_bus ();
  ddr3_core_arb_if #(.ID_W(15)) p1_bus ();
  ddr3_core_arb_if #(.ID_W(16)) core_bus ();

  ddr3_core_arb #(
    .OUTSTANDING_MAX (OMAX),
    .CNT_W           (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p0      (p0_bus),
    .p1      (p1_bus),
    .outport (core_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: requests in flight per port, port the grant is pinned to
  // (-1 = none), last port accepted.
  int m_cnt[2]  = '{0, 0};
  int m_lock    = -1;
  int m_last    = 1;
  bit m_accepted[2] = '{1'b0, 1'b0};

  // Expected values for the current inputs.
  int           x_grant;
  logic [15:0]  x_wr;
  logic         x_rd;
  logic [31:0]  x_addr;
  logic [127:0] x_data;
  logic [15:0]  x_id;
  logic         x_acc[2];
  logic         x_ack[2];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, 128'(act), 128'(exp));
  endtask

  function automatic void compute_expected();
    logic [15:0]  wr[2];
    logic         rd[2];
    logic [31:0]  addr[2];
    logic [127:0] data[2];
    logic [14:0]  id[2];
    bit           elig[2];
    int           dest;
    wr[0] = p0_bus.wr;  rd[0] = p0_bus.rd;  addr[0] = p0_bus.addr;
    data[0] = p0_bus.write_data;  id[0] = p0_bus.req_id;
    wr[1] = p1_bus.wr;  rd[1] = p1_bus.rd;  addr[1] = p1_bus.addr;
    data[1] = p1_bus.write_data;  id[1] = p1_bus.req_id;
    for (int n = 0; n < 2; n++) begin
      elig[n] = ((wr[n] != 16'h0) || rd[n]) && (m_cnt[n] < OMAX);
    end
    x_grant = -1;
    if (!rst) begin
      if (m_lock >= 0)              x_grant = m_lock;
      else if (elig[0] && elig[1]) x_grant = (m_last == 0) ? 1 : 0;
      else if (elig[0])            x_grant = 0;
      else if (elig[1])            x_grant = 1;
    end
    x_wr = '0; x_rd = 1'b0; x_addr = '0; x_data = '0; x_id = '0;
    if (x_grant >= 0) begin
      x_wr   = wr[x_grant];
      x_rd   = rd[x_grant];
      x_addr = addr[x_grant];
      x_data = data[x_grant];
      x_id   = {(x_grant == 1), id[x_grant]};
    end
    dest = core_bus.resp_id[15] ? 1 : 0;
    for (int n = 0; n < 2; n++) begin
      x_acc[n] = (x_grant == n) && core_bus.accept;
      x_ack[n] = !rst && core_bus.ack && (dest == n);
    end
  endfunction

  always @(posedge rst) begin
    m_cnt[0] = 0; m_cnt[1] = 0; m_lock = -1; m_last = 1;
  end

  // Advance the model on every active edge.
  always @(posedge clk) begin
    if (rst) begin
      m_cnt[0] = 0; m_cnt[1] = 0; m_lock = -1; m_last = 1;
      m_accepted[0] = 1'b0; m_accepted[1] = 1'b0;
    end else begin
      compute_expected();
      if (x_grant >= 0) begin
        if (core_bus.accept) begin
          m_last = x_grant;
          m_lock = -1;
        end else begin
          m_lock = x_grant;
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (x_acc[n] && !x_ack[n]) m_cnt[n]++;
        else if (x_ack[n] && !x_acc[n] && m_cnt[n] > 0) m_cnt[n]--;
        m_accepted[n] = x_acc[n];
      end
    end
  end

  // Compare DUT against the model 3 ns after each falling edge (inputs are
  // driven on the falling edge, the active edge follows 2 ns later).
  always @(negedge clk) begin
    #3;
    compute_expected();
    checkOutput("out_wr", 128'(core_bus.wr), 128'(x_wr));
    checkBit("out_rd", core_bus.rd, x_rd);
    if (x_wr != 16'h0 || x_rd) begin
      checkOutput("out_addr", 128'(core_bus.addr), 128'(x_addr));
      checkOutput("out_wdata", core_bus.write_data, x_data);
      checkOutput("out_req_id", 128'(core_bus.req_id), 128'(x_id));
    end
    checkBit("p0_accept", p0_bus.accept, x_acc[0]);
    checkBit("p1_accept", p1_bus.accept, x_acc[1]);
    checkBit("p0_ack", p0_bus.ack, x_ack[0]);
    checkBit("p1_ack", p1_bus.ack, x_ack[1]);
    if (core_bus.ack && !rst) begin
      checkOutput("p0_resp_id", 128'(p0_bus.resp_id), 128'(core_bus.resp_id[14:0]));
      checkOutput("p1_resp_id", 128'(p1_bus.resp_id), 128'(core_bus.resp_id[14:0]));
      checkBit("p0_error", p0_bus.error, core_bus.error);
      checkBit("p1_error", p1_bus.error, core_bus.error);
      checkOutput("p0_rdata", p0_bus.read_data, core_bus.read_data);
      checkOutput("p1_rdata", p1_bus.read_data, core_bus.read_data);
    end
  end

  task automatic set_port(input int n, input logic [15:0] wr, input logic rd,
                          input logic [31:0] addr, input logic [14:0] id);
    logic [127:0] data;
    data = {addr, ~addr, addr ^ 32'h5A5A_5A5A, 17'h0, id};
    if (n == 0) begin
      p0_bus.wr = wr; p0_bus.rd = rd; p0_bus.addr = addr;
      p0_bus.write_data = data; p0_bus.req_id = id;
    end else begin
      p1_bus.wr = wr; p1_bus.rd = rd; p1_bus.addr = addr;
      p1_bus.write_data = data; p1_bus.req_id = id;
    end
  endtask

  task automatic applyStimulus(input logic acc, input logic ack, input logic [15:0] rid,
                               input logic err, input logic [127:0] rdata);
    core_bus.accept    = acc;
    core_bus.ack       = ack;
    core_bus.resp_id   = rid;
    core_bus.error     = err;
    core_bus.read_data = rdata;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_count;
    bit pend[2];
    rst = 1'b0;
    set_port(0, 16'h0, 1'b1, 32'h0, 15'h0);
    set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0, '0);
    #1 rst = 1'b1;
    #2;
    // Reset: request and ack present, everything must stay quiet.
    checkBit("rst_out_rd", core_bus.rd, 1'b0);
    checkOutput("rst_out_wr", 128'(core_bus.wr), 128'(16'h0));
    checkBit("rst_p0_accept", p0_bus.accept, 1'b0);
    checkBit("rst_p0_ack", p0_bus.ack, 1'b0);

    @(negedge clk);
    set_port(0, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0);
    #1 rst = 1'b0;

    // 1: simultaneous reads, p0 wins first, p1 next.
    @(negedge clk);
    set_port(0, 16'h0, 1'b1, 32'h100, 15'h011);
    set_port(1, 16'h0, 1'b1, 32'h200, 15'h022);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
    #2;
    checkBit("t1_p0_accept", p0_bus.accept, 1'b1);
    checkBit("t1_p1_accept", p1_bus.accept, 1'b0);
    checkOutput("t1_req_id0", 128'(core_bus.req_id), 128'(16'h0011));
    checkOutput("t1_addr0", 128'(core_bus.addr), 128'(32'h100));
    @(negedge clk);
    set_port(0, 16'h0, 1'b0, 32'h0, 15'h0);
    #2;
    checkBit("t1b_p1_accept", p1_bus.accept, 1'b1);
    checkOutput("t1_req_id1", 128'(core_bus.req_id), 128'(16'h8022));
    checkOutput("t1_addr1", 128'(core_bus.addr), 128'(32'h200));
    @(negedge clk);
    set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
    set_port(0, 16'h0, 1'b1, 32'h180, 15'h018);
    #2;
    checkBit("t1c_p0_accept", p0_bus.accept, 1'b1);

    // 2: p0 write stalled for 3 cycles; p1 arrives and would win a tie.
    @(negedge clk);
    set_port(0, 16'hFFFF, 1'b0, 32'h300, 15'h033);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0);
    #2;
    checkOutput("t2_out_wr", 128'(core_bus.wr), 128'(16'hFFFF));
    checkBit("t2_p0_accept", p0_bus.accept, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_port(1, 16'h0, 1'b1, 32'h400, 15'h044);
      #2;
      checkOutput("t2_locked_id", 128'(core_bus.req_id), 128'(16'h0033));
      checkBit("t2_p1_blocked", p1_bus.accept, 1'b0);
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
    #2;
    checkBit("t2_p0_accept_late", p0_bus.accept, 1'b1);
    @(negedge clk);
    set_port(0, 16'h0, 1'b0, 32'h0, 15'h0);
    #2;
    checkBit("t2_p1_accept", p1_bus.accept, 1'b1);
    checkOutput("t2_p1_id", 128'(core_bus.req_id), 128'(16'h8044));
    @(negedge clk);
    set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0);

    // Drain: 3 outstanding on p0, 2 on p1.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, (i < 3) ? 16'h0000 : 16'h8000, 1'b0, {4{$urandom}});
    end

    // 3: p0 fills its 8 slots, the 9th waits, p1 is still served.
    acc_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_port(0, 16'h0, 1'b1, 32'h1000 + 32'(i * 16), 15'(i));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
      #2;
      if (p0_bus.accept) acc_count++;
    end
    checkOutput("t3_p0_fill", 128'(acc_count), 128'(8));
    @(negedge clk);
    set_port(0, 16'h0, 1'b1, 32'h2000, 15'h0AA);
    #2;
    checkBit("t3_cap_accept", p0_bus.accept, 1'b0);
    checkBit("t3_cap_out_rd", core_bus.rd, 1'b0);
    @(negedge clk);
    set_port(1, 16'h0, 1'b1, 32'h2100, 15'h0BB);
    #2;
    checkBit("t3_p1_served", p1_bus.accept, 1'b1);
    checkBit("t3_p0_still_cap", p0_bus.accept, 1'b0);
    @(negedge clk);
    set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b1, 1'b1, 16'h0003, 1'b0, {4{32'h1234_5678}});
    #2;
    checkBit("t3_p0_ack", p0_bus.ack, 1'b1);
    checkOutput("t3_p0_resp_id", 128'(p0_bus.resp_id), 128'(15'h0003));
    checkBit("t3_p0_acc_same", p0_bus.accept, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
    #2;
    checkBit("t3_p0_reaccept", p0_bus.accept, 1'b1);

    // 4: error response routed to p1.
    @(negedge clk);
    set_port(0, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b0, 1'b1, 16'h8005, 1'b1, {16{8'hA5}});
    #2;
    checkBit("t4_p1_ack", p1_bus.ack, 1'b1);
    checkBit("t4_p0_ack", p0_bus.ack, 1'b0);
    checkOutput("t4_p1_resp_id", 128'(p1_bus.resp_id), 128'(15'h0005));
    checkBit("t4_p1_error", p1_bus.error, 1'b1);
    checkOutput("t4_p1_rdata", p1_bus.read_data, {16{8'hA5}});

    // 5: same-cycle accept+ack, then a stray ack at zero.
    @(negedge clk);
    set_port(1, 16'h0, 1'b1, 32'h3000, 15'h0CC);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
    @(negedge clk);
    set_port(1, 16'h0, 1'b1, 32'h3010, 15'h0CD);
    applyStimulus(1'b1, 1'b1, 16'h8010, 1'b0, '0);
    #2;
    checkBit("t5_both_acc", p1_bus.accept, 1'b1);
    checkBit("t5_both_ack", p1_bus.ack, 1'b1);
    @(negedge clk);
    set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b0, 1'b1, 16'h8011, 1'b0, '0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h8012, 1'b0, '0);
    #2;
    checkBit("t5_stray_ack", p1_bus.ack, 1'b1);
    acc_count = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_port(1, 16'h0, 1'b1, 32'h4000 + 32'(i * 16), 15'(i));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
      #2;
      if (p1_bus.accept) acc_count++;
    end
    checkOutput("t5_p1_fill", 128'(acc_count), 128'(8));

    // 6: bring p1 down to 3 outstanding with its 9th request now locked,
    // then reset in the middle of the cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 16'h8020 + 16'(i), 1'b0, '0);
    end
    @(negedge clk);
    set_port(0, 16'h0, 1'b1, 32'h5000, 15'h055);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0);
    #1;
    checkBit("t6_locked_rd", core_bus.rd, 1'b1);
    checkOutput("t6_locked_id", 128'(core_bus.req_id), 128'(16'h8008));
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h8000, 1'b0, '0);
    #1;
    checkBit("t6_rst_out_rd", core_bus.rd, 1'b0);
    checkBit("t6_rst_p1_acc", p1_bus.accept, 1'b0);
    checkBit("t6_rst_p1_ack", p1_bus.ack, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
    #1 rst = 1'b0;
    #1;
    checkBit("t6_tie_p0", p0_bus.accept, 1'b1);
    checkBit("t6_tie_p1", p1_bus.accept, 1'b0);
    checkOutput("t6_tie_id", 128'(core_bus.req_id), 128'(16'h0055));
    @(negedge clk);
    set_port(0, 16'h0, 1'b0, 32'h0, 15'h0);
    #2;
    checkBit("t6_p1_next", p1_bus.accept, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
      applyStimulus(1'b0, 1'b1, 16'h8030 + 16'(i), 1'b0, '0);
    end
    acc_count = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      set_port(1, 16'h0, 1'b1, 32'h6000 + 32'(i * 16), 15'(i));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, '0);
      #2;
      if (p1_bus.accept) acc_count++;
    end
    checkOutput("t6_p1_refill", 128'(acc_count), 128'(8));

    // Randomized traffic; requests are held until the model sees them taken.
    @(negedge clk);
    set_port(0, 16'h0, 1'b0, 32'h0, 15'h0);
    set_port(1, 16'h0, 1'b0, 32'h0, 15'h0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, '0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (pend[n] && m_accepted[n]) pend[n] = 1'b0;
        if (!pend[n]) begin
          if ($urandom_range(0, 1) == 1) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            set_port(n, (kind >= 2) ? (16'($urandom) | 16'h1) : 16'h0,
                     (kind != 2), $urandom, 15'($urandom));
            pend[n] = 1'b1;
          end else begin
            set_port(n, 16'h0, 1'b0, 32'h0, 15'h0);
          end
        end
      end
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 2,
                    16'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom});
      if (cyc == 1500) begin
        #1 rst = 1'b1;
        #3 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
